// File: rtl/serial_irq_sequencer.sv
// Hardware interrupt service for the serial IP: read INT_STATUS_CLEAR over AXI4-lite,
// write the value back to clear it, then hand the captured status to a downstream consumer.
module serial_irq_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 5,
    parameter int STATUS_OFS         = 28,
    parameter int HOLDOFF            = 4
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          intr,
    output logic [31:0]                   evt_status,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          busy,
    output logic                          err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_EMIT    = 3'd5
    } state_t;

    localparam logic [7:0]                    HOLDOFF_LD_C = 8'(HOLDOFF);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] REG_ADDR_C   = C_M_AXI_ADDR_WIDTH'(STATUS_OFS);

    state_t      state_r;
    logic        intr_r;
    logic [7:0]  holdoff_r;
    logic [31:0] status_r;
    logic [31:0] evt_status_r;
    logic [31:0] wdata_r;
    logic        arvalid_r;
    logic        rready_r;
    logic        awvalid_r;
    logic        wvalid_r;
    logic        bready_r;
    logic        evt_valid_r;
    logic        busy_r;
    logic        err_r;
    logic        aw_done_s;
    logic        w_done_s;

    // A write channel is finished once its VALID is already low or is being accepted now.
    assign aw_done_s = !awvalid_r || M_AXI_AWREADY;
    assign w_done_s  = !wvalid_r  || M_AXI_WREADY;

    assign M_AXI_AWADDR  = REG_ADDR_C;
    assign M_AXI_ARADDR  = REG_ADDR_C;
    assign M_AXI_WSTRB   = 4'b1111;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_BREADY  = bready_r;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;
    assign evt_status    = evt_status_r;
    assign evt_valid     = evt_valid_r;
    assign busy          = busy_r;
    assign err           = err_r;

    // Sequencer: read status, write it back, emit event, then hold off before re-arming.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_r      <= ST_IDLE;
            intr_r       <= 1'b0;
            holdoff_r    <= 8'd0;
            status_r     <= 32'd0;
            evt_status_r <= 32'd0;
            wdata_r      <= 32'd0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            evt_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            intr_r <= intr;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (holdoff_r != 8'd0) begin
                        holdoff_r <= holdoff_r - 8'd1;
                    end else if (intr_r) begin
                        arvalid_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        status_r <= M_AXI_RDATA;
                        rready_r <= 1'b0;
                        err_r    <= (M_AXI_RRESP != 2'b00);
                        // Zero status means nothing to clear or report.
                        if (M_AXI_RDATA == 32'd0) begin
                            holdoff_r <= HOLDOFF_LD_C;
                            busy_r    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            wdata_r   <= M_AXI_RDATA;
                            state_r   <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_r <= 1'b0;
                    end
                    if (M_AXI_WREADY) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready_r <= 1'b1;
                        state_r  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_r     <= 1'b0;
                        err_r        <= (M_AXI_BRESP != 2'b00);
                        evt_valid_r  <= 1'b1;
                        evt_status_r <= status_r;
                        state_r      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (evt_ready) begin
                        evt_valid_r <= 1'b0;
                        holdoff_r   <= HOLDOFF_LD_C;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid_r   <= 1'b0;
                    rready_r    <= 1'b0;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    evt_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_irq_sequencer.sv
// Bench for serial_irq_sequencer: AXI4-lite slave model with W1C status, event consumer,
// vector table, hand-written corner sequences and randomized sequences against a rule-level model.
module tb_serial_irq_sequencer;

    localparam int              AW_C      = 5;
    localparam int              HOLDOFF_C = 4;
    localparam logic [AW_C-1:0] OFS_C     = 5'd28;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic intr = 1'b0;
    logic evt_ready = 1'b1;
    logic [31:0] evt_status;
    logic evt_valid, busy, err;
    logic [AW_C-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0] M_AXI_WSTRB;
    logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
    logic M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    serial_irq_sequencer #(
        .C_M_AXI_ADDR_WIDTH(AW_C), .STATUS_OFS(28), .HOLDOFF(HOLDOFF_C)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .intr(intr),
        .evt_status(evt_status), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .busy(busy), .err(err),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration, written only by the stimulus process.
    logic [31:0] cfg_status = 32'd0;
    int          cfg_gen    = 0;
    logic [1:0]  cfg_rresp  = 2'd0;
    logic [1:0]  cfg_bresp  = 2'd0;
    int cfg_ar_d = 0, cfg_r_d = 0, cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0;

    // Observation logs, written only by the slave/monitor process.
    logic [AW_C-1:0] ar_q[$];
    logic [AW_C-1:0] aw_q[$];
    logic [35:0]     w_q[$];
    logic [31:0]     evt_q[$];
    int err_cycles = 0, proto_viol = 0, w_first_cnt = 0, evt_hi_cycles = 0;

    // Log positions at the start of the current sequence.
    int b_ar, b_aw, b_w, b_evt, b_err, b_proto, b_wfirst, b_evthi;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        b_ar = ar_q.size(); b_aw = aw_q.size(); b_w = w_q.size(); b_evt = evt_q.size();
        b_err = err_cycles; b_proto = proto_viol; b_wfirst = w_first_cnt; b_evthi = evt_hi_cycles;
    endtask

    // AXI4-lite slave with a W1C status register plus bus monitor, all on the falling edge.
    initial begin : slave
        logic [31:0] cur_status;
        int seen_gen, ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        bit rd_pend, wr_armed, aw_got, w_got;
        logic p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready, p_evt_valid, p_evt_ready;
        logic [31:0] p_evt_status;
        cur_status = 32'd0; seen_gen = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_pend = 0; wr_armed = 0; aw_got = 0; w_got = 0;
        p_arvalid = 0; p_rready = 0; p_awvalid = 0; p_wvalid = 0; p_bready = 0;
        p_evt_valid = 0; p_evt_ready = 0; p_evt_status = 32'd0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 32'd0; M_AXI_RRESP = 2'd0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 2'd0;
        forever begin
            @(negedge clk);
            if (seen_gen != cfg_gen) begin
                cur_status = cfg_status;
                seen_gen   = cfg_gen;
            end
            if (!rst_n) begin
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
                rd_pend = 0; wr_armed = 0; aw_got = 0; w_got = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                p_arvalid = 0; p_rready = 0; p_awvalid = 0; p_wvalid = 0; p_bready = 0;
                p_evt_valid = 0; p_evt_ready = 0;
            end else begin
                // handshakes completed at the preceding rising edge
                if (p_arvalid && M_AXI_ARREADY) begin ar_q.push_back(M_AXI_ARADDR); rd_pend = 1; r_cnt = 0; end
                if (p_rready && M_AXI_RVALID) begin M_AXI_RVALID = 0; rd_pend = 0; end
                if (p_awvalid && M_AXI_AWREADY) begin aw_q.push_back(M_AXI_AWADDR); aw_got = 1; end
                if (p_wvalid && M_AXI_WREADY) begin
                    w_q.push_back({M_AXI_WSTRB, M_AXI_WDATA});
                    cur_status = cur_status & ~M_AXI_WDATA;
                    w_got = 1;
                end
                if (p_bready && M_AXI_BVALID) M_AXI_BVALID = 0;
                if (p_evt_valid && p_evt_ready) evt_q.push_back(p_evt_status);
                // monitor
                if (err) err_cycles++;
                if (evt_valid) evt_hi_cycles++;
                if ((M_AXI_AWVALID && !p_awvalid) != (M_AXI_WVALID && !p_wvalid)) proto_viol++;
                if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) proto_viol++;
                if ((M_AXI_ARVALID || M_AXI_RREADY) && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY)) proto_viol++;
                if (M_AXI_AWVALID && !M_AXI_WVALID) w_first_cnt++;
                // drive next responses
                if (M_AXI_ARVALID && !rd_pend) begin
                    if (ar_cnt >= cfg_ar_d) begin M_AXI_ARREADY = 1; ar_cnt = 0; end
                    else begin M_AXI_ARREADY = 0; ar_cnt++; end
                end else M_AXI_ARREADY = 0;
                if (rd_pend && !M_AXI_RVALID) begin
                    if (r_cnt >= cfg_r_d) begin M_AXI_RVALID = 1; M_AXI_RDATA = cur_status; M_AXI_RRESP = cfg_rresp; end
                    else r_cnt++;
                end
                if (M_AXI_AWVALID && M_AXI_WVALID) wr_armed = 1;
                if (wr_armed && M_AXI_AWVALID) begin
                    if (aw_cnt >= cfg_aw_d) M_AXI_AWREADY = 1;
                    else begin M_AXI_AWREADY = 0; aw_cnt++; end
                end else M_AXI_AWREADY = 0;
                if (wr_armed && M_AXI_WVALID) begin
                    if (w_cnt >= cfg_w_d) M_AXI_WREADY = 1;
                    else begin M_AXI_WREADY = 0; w_cnt++; end
                end else M_AXI_WREADY = 0;
                if (aw_got && w_got && !M_AXI_BVALID) begin
                    if (b_cnt >= cfg_b_d) begin
                        M_AXI_BVALID = 1; M_AXI_BRESP = cfg_bresp;
                        aw_got = 0; w_got = 0; wr_armed = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                p_arvalid = M_AXI_ARVALID; p_rready = M_AXI_RREADY; p_awvalid = M_AXI_AWVALID;
                p_wvalid = M_AXI_WVALID; p_bready = M_AXI_BREADY;
                p_evt_valid = evt_valid; p_evt_ready = evt_ready; p_evt_status = evt_status;
            end
        end
    end

    task automatic run_seq(input logic [31:0] st, input logic [1:0] rr, input logic [1:0] br,
                           input int ard, input int rd, input int awd, input int wd, input int bd,
                           input string tag);
        int t;
        mark();
        cfg_status = st; cfg_gen++; cfg_rresp = rr; cfg_bresp = br;
        cfg_ar_d = ard; cfg_r_d = rd; cfg_aw_d = awd; cfg_w_d = wd; cfg_b_d = bd;
        intr = 1'b1;
        t = 0;
        while (!busy && t < 50) begin tick(); t++; end
        check({tag, ".busy_rise"}, busy, 1);
        intr = 1'b0;
        t = 0;
        while (busy && t < 300) begin tick(); t++; end
        check({tag, ".busy_fall"}, busy, 0);
        repeat (HOLDOFF_C + 4) tick();
    endtask

    task automatic expect_seq(input string tag, input logic [31:0] st, input bit exp_wr,
                              input bit exp_evt, input int exp_err);
        int n_ar, n_aw, n_w, n_evt;
        n_ar = ar_q.size() - b_ar; n_aw = aw_q.size() - b_aw;
        n_w = w_q.size() - b_w;    n_evt = evt_q.size() - b_evt;
        check({tag, ".ar_n"}, n_ar, 1);
        if (n_ar >= 1) check({tag, ".ar_addr"}, ar_q[b_ar], OFS_C);
        check({tag, ".aw_n"}, n_aw, exp_wr);
        check({tag, ".w_n"}, n_w, exp_wr);
        if (exp_wr && n_aw >= 1) check({tag, ".aw_addr"}, aw_q[b_aw], OFS_C);
        if (exp_wr && n_w >= 1) check({tag, ".w_strb_data"}, w_q[b_w], {4'hF, st});
        check({tag, ".evt_n"}, n_evt, exp_evt);
        if (exp_evt && n_evt >= 1) check({tag, ".evt_status"}, evt_q[b_evt], st);
        check({tag, ".evt_valid_cycles"}, evt_hi_cycles - b_evthi, exp_evt);
        check({tag, ".err_cycles"}, err_cycles - b_err, exp_err);
        check({tag, ".protocol"}, proto_viol - b_proto, 0);
    endtask

    typedef struct {
        logic [31:0] status;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        int ar_d, r_d, aw_d, w_d, b_d;
        bit exp_wr;
        bit exp_evt;
        int exp_err;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, actual running required finished");
        $fatal(1);
    end

    initial begin : stim
        vec_t vecs[7];
        int t, gap, unstable;
        logic [31:0] s0, rst_st;
        logic [1:0] rr, br;
        bit m_wr;
        int m_err;

        vecs[0] = '{32'h0000_0005, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 0};
        vecs[1] = '{32'h0000_0000, 2'd0, 2'd0, 1, 1, 0, 0, 0, 1'b0, 1'b0, 0};
        vecs[2] = '{32'h0000_0001, 2'd2, 2'd0, 0, 2, 0, 0, 0, 1'b1, 1'b1, 1};
        vecs[3] = '{32'hA5A5_0F0F, 2'd0, 2'd1, 2, 0, 1, 1, 3, 1'b1, 1'b1, 1};
        vecs[4] = '{32'h0000_0001, 2'd2, 2'd3, 1, 1, 0, 2, 1, 1'b1, 1'b1, 2};
        vecs[5] = '{32'h0000_0000, 2'd3, 2'd0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1};
        vecs[6] = '{32'hFFFF_FFFF, 2'd0, 2'd0, 3, 3, 2, 0, 0, 1'b1, 1'b1, 0};

        repeat (2) tick();
        check("reset.ctrl", {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID,
                             M_AXI_BREADY, evt_valid, busy, err}, 8'h00);
        check("reset.evt_status", evt_status, 32'd0);
        check("reset.wdata", M_AXI_WDATA, 32'd0);
        check("const.araddr", M_AXI_ARADDR, OFS_C);
        check("const.wstrb", M_AXI_WSTRB, 4'hF);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_seq(vecs[i].status, vecs[i].rresp, vecs[i].bresp, vecs[i].ar_d, vecs[i].r_d,
                    vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d, $sformatf("vec%0d", i));
            expect_seq($sformatf("vec%0d", i), vecs[i].status, vecs[i].exp_wr, vecs[i].exp_evt, vecs[i].exp_err);
        end

        // spurious interrupt with intr held: no re-read until the holdoff expires
        mark();
        cfg_status = 32'd0; cfg_gen++; cfg_rresp = 2'd0; cfg_bresp = 2'd0;
        cfg_ar_d = 0; cfg_r_d = 0; cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0;
        intr = 1'b1;
        t = 0;
        while (!busy && t < 50) begin tick(); t++; end
        check("hold.busy_rise", busy, 1);
        t = 0;
        while (busy && t < 50) begin tick(); t++; end
        check("hold.busy_fall", busy, 0);
        gap = 0;
        while (!M_AXI_ARVALID && gap < 40) begin tick(); gap++; end
        check("hold.gap_in_range", (gap >= HOLDOFF_C) && (gap <= HOLDOFF_C + 2), 1);
        intr = 1'b0;
        t = 0;
        while (busy && t < 50) begin tick(); t++; end
        repeat (HOLDOFF_C + 4) tick();
        check("hold.ar_n", ar_q.size() - b_ar, 2);
        check("hold.aw_n", aw_q.size() - b_aw, 0);
        check("hold.evt_n", evt_q.size() - b_evt, 0);
        check("hold.err", err_cycles - b_err, 0);

        // stalled consumer for 20 cycles with intr still asserted
        mark();
        cfg_status = 32'h8000_0000; cfg_gen++;
        evt_ready = 1'b0;
        intr = 1'b1;
        t = 0;
        while (!evt_valid && t < 100) begin tick(); t++; end
        check("stall.evt_valid", evt_valid, 1);
        s0 = evt_status;
        check("stall.evt_status", s0, 32'h8000_0000);
        unstable = 0;
        repeat (20) begin
            tick();
            if (!evt_valid || evt_status !== s0 || !busy) unstable++;
        end
        check("stall.stable_cycles", unstable, 0);
        check("stall.no_new_ar", ar_q.size() - b_ar, 1);
        check("stall.no_evt_yet", evt_q.size() - b_evt, 0);
        intr = 1'b0;
        evt_ready = 1'b1;
        t = 0;
        while (busy && t < 50) begin tick(); t++; end
        check("stall.busy_fall", busy, 0);
        repeat (HOLDOFF_C + 4) tick();
        check("stall.evt_n", evt_q.size() - b_evt, 1);
        if (evt_q.size() > b_evt) check("stall.evt_val", evt_q[b_evt], 32'h8000_0000);

        // AWREADY three cycles after WREADY
        run_seq(32'h0000_0040, 2'd0, 2'd0, 0, 0, 3, 0, 0, "awdly");
        expect_seq("awdly", 32'h0000_0040, 1'b1, 1'b1, 0);
        check("awdly.w_drop_first", (w_first_cnt - b_wfirst) > 0, 1);

        // asynchronous reset while waiting for the write response
        mark();
        cfg_status = 32'h0000_0077; cfg_gen++; cfg_aw_d = 0; cfg_b_d = 10;
        intr = 1'b1;
        t = 0;
        while (!M_AXI_BREADY && t < 100) begin tick(); t++; end
        check("rst.reach_wr_resp", M_AXI_BREADY, 1);
        intr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.ctrl", {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID,
                           M_AXI_BREADY, evt_valid, busy, err}, 8'h00);
        check("rst.evt_status", evt_status, 32'd0);
        check("rst.wdata", M_AXI_WDATA, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_seq(32'h0000_0033, 2'd0, 2'd0, 0, 0, 0, 0, 0, "rst_restart");
        expect_seq("rst_restart", 32'h0000_0033, 1'b1, 1'b1, 0);

        // randomized sequences against the rule-level expectation
        for (int i = 0; i < 24; i++) begin
            rst_st = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            br = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            m_wr  = (rst_st != 32'd0);
            m_err = ((rr != 2'd0) ? 1 : 0) + ((m_wr && br != 2'd0) ? 1 : 0);
            run_seq(rst_st, rr, br, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", i));
            expect_seq($sformatf("rnd%0d", i), rst_st, m_wr, m_wr, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_irq_sequencer.md
Name: serial_irq_sequencer

Overview:
- AXI4-lite master that services the serial IP interrupt in hardware; no CPU involvement.
- On a rising `intr` it performs three steps: reads the INT_STATUS_CLEAR register (offset 28), writes the same value back to clear it (W1C), and presents the captured status on a valid/ready event port.
- Sits between the serial IP AXI slave port and a downstream event consumer (FIFO or DMA descriptor logic).

Parameters:
- C_M_AXI_ADDR_WIDTH, 5, address bus width; must be ≥5 so that bits [4:2] select the register.
- STATUS_OFS, 28, byte offset of the INT_STATUS_CLEAR register.
- HOLDOFF, 4, idle cycles after the clear before `intr` is sampled again; covers the slave's status-clear and input-synchroniser latency; range 1..255.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
intr  in  1  level interrupt from the serial IP
evt_status  out  32  captured int_status value
evt_valid  out  1  event valid
evt_ready  in  1  consumer accepts event
busy  out  1  high whenever state≠IDLE
err  out  1  one-cycle pulse when BRESP or RRESP≠0
M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  32  write data (status to clear)
M_AXI_WSTRB  out  4  constant 4'b1111
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - All VALID/READY outputs, `evt_valid`, `busy` and `err` = 0.
  - `evt_status` = 0, `M_AXI_WDATA` = 0.
  - State = IDLE; holdoff counter = 0.
- Address outputs: `M_AXI_ARADDR` = `M_AXI_AWADDR` = STATUS_OFS, constant.
- IDLE:
  - Holdoff counter must be 0 and `intr`=1 (registered sample) to leave IDLE.
  - On that condition, next cycle ARVALID=1 and state → RD_ADDR.
- RD_ADDR: hold ARVALID until ARREADY is sampled high, then ARVALID=0, RREADY=1, state → RD_DATA.
- RD_DATA: on RVALID&RREADY:
  - Capture RDATA into the status register; RREADY=0.
  - `err` pulses if RRESP≠0.
  - If captured value = 0 (spurious interrupt): state → IDLE and load holdoff = HOLDOFF.
  - Otherwise: AWVALID=1, WVALID=1, WDATA=status, state → WR.
- WR:
  - AWVALID and WVALID are always raised in the same cycle, because the slave requires both before asserting either ready.
  - Each VALID is dropped independently on its own READY.
  - When both have handshaken, BREADY=1, state → WR_RESP.
- WR_RESP:
  - On BVALID&BREADY: BREADY=0; `err` pulses if BRESP≠0.
  - `evt_valid`=1 with `evt_status`=status; state → EMIT.
- EMIT:
  - Hold `evt_valid` and `evt_status` stable until `evt_ready`=1.
  - Then `evt_valid`=0, load holdoff = HOLDOFF, state → IDLE.
  - A stalled consumer stalls the sequencer; further interrupts accumulate in the slave's sticky status.
- Holdoff: counter decrements once per cycle in IDLE down to 0.
  - Level-mode sources still asserted after holdoff retrigger a new sequence; this is intended.
- `intr` changes while not in IDLE are ignored; the status reflects whatever the read returned.
- `err` does not abort the sequence; the failed step is treated as completed.
- At most one AXI transaction is outstanding; read and write are never overlapped.

Test Plan:
- Slave model status=0x0000_0005, `intr` rises, `evt_ready`=1 → AR to addr 28; W to addr 28 with 0x0000_0005, WSTRB=0xF; `evt_valid` one cycle with evt_status=0x0000_0005; `busy` falls.
- `intr` rises but slave returns 0 → no write issued, no event, `err`=0, back to IDLE; no re-read for 4 cycles.
- `evt_ready` held low 20 cycles with status=0x8000_0000 → `evt_valid` and `evt_status` stable for all 20 cycles, no new AR issued; completes when `evt_ready`=1.
- Slave delays AWREADY 3 cycles after WREADY → WVALID drops on WREADY, AWVALID held, BREADY only after both handshakes, single write observed.
- RRESP=2'b10 with data 0x1 → `err` pulses one cycle, clear write of 0x1 still issued, event still emitted.
- Reset asserted while in WR_RESP → all outputs 0 asynchronously (before next clock edge); after release, `intr`=1 starts a fresh read.
